// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receiver and its echo transmitter.
// Frame: start, 8 data bits LSB first, even parity, stop.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 20;
    localparam int DATA_BITS        = 8;
    localparam int FRAME_BITS       = 11;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

endpackage

// File: rtl/uart_transmitter.sv
// Serial transmitter: start bit, data[0..8] LSB first, stop bit.
// data[8] carries a caller-supplied parity bit.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] data,
    input  logic       send,
    input  logic       rx_i,
    output logic       busy,
    output logic       tx_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(FRAME_BITS);

    logic                  busy_q, busy_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  unused_rx;

    assign unused_rx = rx_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q  <= 1'b0;
            frame_q <= '1;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            busy_q  <= busy_d;
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        busy_d  = busy_q;
        frame_d = frame_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (!busy_q) begin
            if (send) begin
                busy_d  = 1'b1;
                frame_d = {1'b1, data, 1'b0};
                cnt_d   = '0;
                idx_d   = '0;
            end
        end else if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
            cnt_d = '0;
            if (idx_q == IW'(FRAME_BITS - 1)) begin
                busy_d = 1'b0;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign busy = busy_q;
    assign tx_o = busy_q ? frame_q[idx_q] : 1'b1;

endmodule

// File: rtl/uart_receive.sv
// UART receiver with even-parity check, sticky ready flag and
// echo of each accepted byte through uart_transmitter.
module uart_receive
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_i,
    input  logic       reset_ready,
    output logic [7:0] data,
    output logic       ready,
    output logic       tx_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    rx_state_e      state_q, state_d;
    logic           sync1_q, sync2_q, prev_q;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic [7:0]     data_q, data_d;
    logic           ready_q, ready_d;
    logic           tick_half, tick_bit;
    logic           accept, send, tx_busy;

    assign tick_half = (cnt_q == CW'(HALF_BIT - 1));
    assign tick_bit  = (cnt_q == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            ready_q <= ready_d;
        end
    end

    // Next state plus bit-timing datapath.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (prev_q && !sync2_q) state_d = START;
            end
            START: begin
                if (tick_half) begin
                    cnt_d   = '0;
                    state_d = sync2_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick_bit) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                if (tick_bit) begin
                    cnt_d   = '0;
                    par_d   = sync2_q;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick_bit) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Acceptance takes priority over a simultaneous ready clear.
    always_comb begin
        accept  = (state_q == STOP) && tick_bit && sync2_q &&
                  !(^{shift_q, par_q});
        send    = accept && !tx_busy;
        data_d  = accept ? shift_q : data_q;
        ready_d = accept || (ready_q && !reset_ready);
    end

    uart_transmitter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk  (clk),
        .reset(reset),
        .data ({par_q, shift_q}),
        .send (send),
        .rx_i (rx_i),
        .busy (tx_busy),
        .tx_o (tx_o)
    );

    assign data  = data_q;
    assign ready = ready_q;

endmodule

// File: tb/tb_uart_receive.sv
// Randomized bench for uart_receive against a frame-level model,
// plus a standalone check of uart_transmitter.
module tb_uart_receive;

    localparam int CPB  = 20;
    localparam int HALF = CPB / 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rr;
    logic [7:0] data;
    logic       ready;
    logic       tx_o;

    logic [8:0] tdata;
    logic       tsend;
    logic       tbusy;
    logic       tline;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_data;
    logic       m_ready;
    logic [9:0] echo_q[$];

    always #5 clk = ~clk;

    uart_receive #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (rst),
        .rx_i       (rx),
        .reset_ready(rr),
        .data       (data),
        .ready      (ready),
        .tx_o       (tx_o)
    );

    uart_transmitter #(.CLKS_PER_BIT(CPB)) u_txs (
        .clk  (clk),
        .reset(rst),
        .data (tdata),
        .send (tsend),
        .rx_i (1'b1),
        .busy (tbusy),
        .tx_o (tline)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Decode echoed frames from tx_o into {stop, parity, data}.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_o === 1'b0) begin
                logic [9:0] w;
                w = '0;
                repeat (HALF - 1) @(negedge clk);
                if (tx_o === 1'b0) begin
                    for (int i = 0; i < 10; i++) begin
                        repeat (CPB) @(negedge clk);
                        w[i] = tx_o;
                    end
                    echo_q.push_back(w);
                end
            end
        end
    end

    task automatic drive_bits(input logic [7:0] b, input logic par,
                              input logic stp, input bit coin);
        logic [10:0] bits;
        bits = {stp, par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (c == 0) rx = bits[i];
                if (coin && i == 10) begin
                    if (c == 0) rr = 1'b1;
                    else if (data === b) rr = 1'b0;
                end
            end
        end
        @(negedge clk);
        rx = 1'b1;
        rr = 1'b0;
    endtask

    task automatic do_frame(input logic [7:0] b, input bit perr,
                            input bit serr, input bit coin);
        logic par;
        bit   acc;
        par = (^b) ^ perr;
        acc = !perr && !serr;
        drive_bits(b, par, !serr, coin);
        if (acc) begin
            m_data  = b;
            m_ready = 1'b1;
        end else if (coin) begin
            m_ready = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        chk("rx_data", data, m_data);
        chk("rx_ready", ready, m_ready);
        repeat (11 * CPB) @(negedge clk);
        chk("echo_n", echo_q.size(), acc ? 1 : 0);
        if (acc && echo_q.size() > 0)
            chk("echo_w", echo_q[0], {1'b1, par, b});
        echo_q.delete();
    endtask

    task automatic pulse_rr();
        @(negedge clk);
        rr = 1'b1;
        @(negedge clk);
        rr = 1'b0;
        m_ready = 1'b0;
        chk("rr_clr", ready, m_ready);
    endtask

    task automatic glitch();
        int len;
        len = $urandom_range(2, 8);
        @(negedge clk);
        rx = 1'b0;
        repeat (len) @(negedge clk);
        rx = 1'b1;
        repeat (13 * CPB) @(negedge clk);
        chk("gl_ready", ready, m_ready);
        chk("gl_data", data, m_data);
        chk("gl_echo", echo_q.size(), 0);
        echo_q.delete();
    endtask

    task automatic tx_test();
        logic [10:0] got;
        int          nbusy;
        got   = '0;
        nbusy = 0;
        tdata = 9'b1_0101_0111;
        @(negedge clk);
        tsend = 1'b1;
        @(negedge clk);
        tsend = 1'b0;
        for (int c = 0; c < 11 * CPB; c++) begin
            if (tbusy) nbusy++;
            if (c % CPB == HALF) got[c / CPB] = tline;
            if (c == 50) begin
                tsend = 1'b1;
                tdata = 9'h0AA;
            end
            if (c == 51) tsend = 1'b0;
            @(negedge clk);
        end
        chk("tx_busy_n", nbusy, 11 * CPB);
        chk("tx_busy_end", tbusy, 1'b0);
        chk("tx_bits", got, 11'b110_1010_1110);
        repeat (30) @(negedge clk);
        chk("tx_ignore", tbusy, 1'b0);
        chk("tx_idle", tline, 1'b1);
    endtask

    initial begin
        logic [7:0] b;
        int         e;
        rst   = 1'b1;
        rx    = 1'b1;
        rr    = 1'b0;
        tsend = 1'b0;
        tdata = '0;
        m_data  = 8'h00;
        m_ready = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_data", data, 8'h00);
        chk("rst_ready", ready, 1'b0);
        chk("rst_tx", tx_o, 1'b1);
        chk("rst_tbusy", tbusy, 1'b0);
        chk("rst_tline", tline, 1'b1);
        rst = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        chk("idle_data", data, 8'h00);
        chk("idle_ready", ready, 1'b0);
        chk("idle_tx", tx_o, 1'b1);

        do_frame(8'h1D, 1'b0, 1'b0, 1'b0);
        do_frame(8'h1D, 1'b1, 1'b0, 1'b0);
        do_frame(8'h62, 1'b0, 1'b1, 1'b0);
        pulse_rr();
        do_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        do_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        do_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        pulse_rr();
        glitch();
        do_frame(8'h7E, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 24; k++) begin
            b = 8'($urandom);
            e = $urandom_range(0, 7);
            do_frame(b, e < 2, e == 2, 1'b0);
            if ($urandom_range(0, 2) == 0) pulse_rr();
            if ($urandom_range(0, 5) == 0) glitch();
        end

        tx_test();

        // Accept a byte, then reset in the middle of the next frame.
        drive_bits(8'h96, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5 * CPB; i++) begin
            @(negedge clk);
            if (i == 0) rx = 1'b0;
            if (i == CPB) rx = 1'b1;
        end
        chk("pre_rst_ready", ready, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_data", data, 8'h00);
        chk("mid_rst_ready", ready, 1'b0);
        chk("mid_rst_tx", tx_o, 1'b1);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        chk("post_rst_tx", tx_o, 1'b1);
        echo_q.delete();
        m_data  = 8'h00;
        m_ready = 1'b0;
        do_frame(8'h5B, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_receive.md
Name: uart_receive

Overview:
- UART receiver for frames of 1 start bit, 8 data bits sent LSB first, 1 even-parity bit and 1 stop bit.
- Bit period is CLKS_PER_BIT system clocks; default 20, i.e. 400 ns at a 50 MHz clock.
- Each accepted byte is presented on `data` with a sticky `ready` flag, and is echoed back on `tx_o`.
- The echo goes through an internal transmitter, uart_transmitter.
- The block sits between an external serial line and a host-side consumer.

Parameters:
- CLKS_PER_BIT, 20, system clocks per serial bit; must be at least 4 and even.
- HALF_BIT, CLKS_PER_BIT/2, offset from the start-bit edge to the first mid-bit sample.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx_i  input  1  serial input; idles high.
- reset_ready  input  1  single-cycle pulse that clears `ready`.
- data  output  8  last accepted byte.
- ready  output  1  high while an unconsumed byte is held in `data`.
- tx_o  output  1  serial echo output; idles high.

Behaviour:
- Reset values: `data` = 0x00, `ready` = 0, `tx_o` = 1, receiver FSM in IDLE, internal transmitter idle.
- A reset asserted mid-frame aborts both directions immediately.
- rx_i passes through a 2-flop synchronizer. All decisions below use the synchronized value.
- Receiver FSM states:
  - IDLE: a 1-to-0 transition moves to START and clears the bit counter.
  - START: after HALF_BIT clocks, sample the line. If low, go to DATA; if high (a glitch), return to IDLE.
  - DATA: every CLKS_PER_BIT clocks, shift the sample into bit[i], for i = 0..7, LSB first.
  - PARITY: one CLKS_PER_BIT later, sample the parity bit.
  - STOP: one CLKS_PER_BIT later, sample the stop bit, then return to IDLE.
- Frame acceptance:
  - The frame is accepted only if the stop bit is 1 and the XOR of the 8 data bits plus the parity bit is 0 (even parity).
  - On acceptance, the cycle after the stop sample: `data` is updated and `ready` is set to 1.
  - A rejected frame (parity or framing error) is dropped silently; `data` and `ready` are unchanged.
- `ready` handshake:
  - `ready` stays high until reset_ready is sampled high.
  - If reset_ready and an acceptance occur in the same cycle, acceptance wins and `ready` = 1.
  - Overrun: a new acceptance while `ready` = 1 overwrites `data`, and `ready` stays 1.
- Echo:
  - On acceptance, if the internal transmitter is not busy, it is sent the 9-bit word {parity, data}.
  - If the transmitter is busy, the echo is dropped.
- Sub-module uart_transmitter, ports: clk, reset, data[8:0], send, rx_i, busy, tx_o.
  - rx_i is accepted and ignored.
  - Reset values: busy = 0, tx_o = 1.
  - When send is sampled high while busy = 0, it latches data[8:0]; busy rises on the next cycle.
  - It then drives, each bit for CLKS_PER_BIT clocks: the start bit 0, then data[0] through data[8], then the stop bit 1.
  - busy falls after the stop bit, 11 bit periods (220 clocks at default) after it rose.
  - send while busy is ignored.
  - The caller supplies the parity bit in data[8]; the transmitter does not compute parity.

Decomposition:
- Shared package uart_pkg:
  - Default CLKS_PER_BIT.
  - Frame constants: DATA_BITS = 8, FRAME_BITS = 11.
  - Receiver state enum: IDLE, START, DATA, PARITY, STOP.
- One sub-module, uart_transmitter, instantiated inside uart_receive to drive tx_o.
- The transmitter is independently usable and is verified standalone.

Test Plan:
1. Reset held high with rx_i = 1 -> `data` = 0x00, `ready` = 0, `tx_o` = 1; after release these stay unchanged while the line idles.
2. Frame with bits start 0, data 1,0,1,1,1,0,0,0, parity 0, stop 1, at 400 ns per bit -> `ready` rises within 2 bit periods of the stop mid-point and `data` = 0x1D. `tx_o` then echoes start, 0x1D LSB first, parity 0, stop.
3. Same frame with parity 1 -> `ready` stays 0, `data` unchanged, no echo. Separately, stop bit 0 -> frame dropped.
4. While `ready` = 1, pulse reset_ready for one clock -> `ready` = 0 the next cycle. reset_ready coincident with a new acceptance -> `ready` = 1 with the new byte.
5. Standalone uart_transmitter with data = 9'b1_0101_0111 and send pulsed for 1 clock -> busy high for 220 clocks. tx_o = 0, then 1,1,1,0,1,0,1,0, then 1 (parity), then 1 (stop), each held 20 clocks. A second send while busy is ignored.
6. Low glitch on rx_i shorter than 10 clocks -> receiver returns to IDLE, `ready` stays 0. Reset asserted mid-frame -> all outputs return to reset values immediately.
